// File: rtl/rvlab_shift_unit.sv
// rvlab_shift_unit: pipelined barrel shifter supporting LSL/LSR/ASR/ROL/ROR.
// The shift is decomposed into binary levels (shift by 2^k). The levels are
// spread evenly over STAGES register stages. Mode, amount, carry and error
// status travel alongside the data. A single global stall freezes every stage
// whenever the output is valid but not accepted.
module rvlab_shift_unit #(
    parameter  int WIDTH  = 32,
    parameter  int STAGES = 2,
    localparam int AMT_W  = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [AMT_W-1:0] in_amt_i,
    input  logic [2:0]       in_mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_carry_o,
    output logic             out_zero_o,
    output logic             out_err_o,
    input  logic             cnt_clr_i,
    output logic [15:0]      op_count_o,
    output logic             busy_o
);

    // Number of binary shift levels handled by each stage.
    localparam int LPS = (AMT_W + STAGES - 1) / STAGES;

    localparam logic [2:0] MODE_LSL = 3'd0;
    localparam logic [2:0] MODE_LSR = 3'd1;
    localparam logic [2:0] MODE_ASR = 3'd2;
    localparam logic [2:0] MODE_ROL = 3'd3;
    localparam logic [2:0] MODE_ROR = 3'd4;

    logic              stall_s;
    logic              last_vld_s;
    logic [WIDTH-1:0]  last_data_s;
    logic              last_carry_s;
    logic              last_err_s;
    logic [STAGES-1:0] vld_vec_s;
    logic [15:0]       cnt_r;

    // Modes 5..7 are rejected; such requests pass their data through untouched.
    function automatic logic mode_illegal(input logic [2:0] mode);
        logic ill;
        case (mode)
            MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROL, MODE_ROR: ill = 1'b0;
            default:                                          ill = 1'b1;
        endcase
        return ill;
    endfunction

    // One shift level by sh = 2^k; returns {carry, result}. The carry is the
    // last bit leaving the word. Because every later level shifts further, the
    // carry of the final active level equals the carry of the whole shift.
    function automatic logic [WIDTH:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       mode,
                                                   input int               sh);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] tmp;
        logic             c;
        r   = d;
        tmp = d;
        c   = 1'b0;
        case (mode)
            MODE_LSL: begin
                r   = d << sh;
                tmp = d >> (WIDTH - sh);
                c   = tmp[0];
            end
            MODE_LSR: begin
                r   = d >> sh;
                tmp = d >> (sh - 1);
                c   = tmp[0];
            end
            MODE_ASR: begin
                r   = $signed(d) >>> sh;
                tmp = d >> (sh - 1);
                c   = tmp[0];
            end
            MODE_ROL: begin
                r = (d << sh) | (d >> (WIDTH - sh));
                c = r[0];
            end
            MODE_ROR: begin
                r = (d >> sh) | (d << (WIDTH - sh));
                c = r[WIDTH-1];
            end
            default: begin
                r = d;
                c = 1'b0;
            end
        endcase
        return {c, r};
    endfunction

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = s * LPS;
        localparam int HI = (((s + 1) * LPS) < AMT_W) ? ((s + 1) * LPS) : AMT_W;

        logic             src_vld_s;
        logic [WIDTH-1:0] src_data_s;
        logic [AMT_W-1:0] src_amt_s;
        logic [2:0]       src_mode_s;
        logic             src_carry_s;
        logic             src_err_s;
        logic [WIDTH-1:0] nxt_data_s;
        logic             nxt_carry_s;
        logic [AMT_W-1:0] amt_sh_s;
        logic [WIDTH:0]   lvl_s;
        logic             vld_r;
        logic [WIDTH-1:0] data_r;
        logic             carry_r;
        logic             err_r;

        if (s == 0) begin : g_src
            assign src_vld_s   = in_valid_i;
            assign src_data_s  = in_data_i;
            assign src_amt_s   = in_amt_i;
            assign src_mode_s  = in_mode_i;
            assign src_carry_s = 1'b0;
            assign src_err_s   = mode_illegal(in_mode_i);
        end else begin : g_src
            assign src_vld_s   = g_stage[s-1].vld_r;
            assign src_data_s  = g_stage[s-1].data_r;
            assign src_amt_s   = g_stage[s-1].g_fwd.amt_r;
            assign src_mode_s  = g_stage[s-1].g_fwd.mode_r;
            assign src_carry_s = g_stage[s-1].carry_r;
            assign src_err_s   = g_stage[s-1].err_r;
        end

        // Apply this stage's share of the shift levels (LO .. HI-1).
        always_comb begin
            nxt_data_s  = src_data_s;
            nxt_carry_s = src_carry_s;
            amt_sh_s    = {AMT_W{1'b0}};
            lvl_s       = {(WIDTH + 1){1'b0}};
            for (int k = 0; k < AMT_W; k++) begin
                amt_sh_s = src_amt_s >> k;
                if ((k >= LO) && (k < HI) && amt_sh_s[0] && !src_err_s) begin
                    lvl_s       = shift_level(nxt_data_s, src_mode_s, 32'sd1 << k);
                    nxt_data_s  = lvl_s[WIDTH-1:0];
                    nxt_carry_s = lvl_s[WIDTH];
                end else begin
                    nxt_carry_s = nxt_carry_s;
                end
            end
        end

        // Stage valid bit: cleared by reset, frozen while stalled.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_r <= 1'b0;
            end else if (!stall_s) begin
                vld_r <= src_vld_s;
            end else begin
                vld_r <= vld_r;
            end
        end

        // Stage payload: advances with the pipeline, holds while stalled.
        always_ff @(posedge clk_i) begin
            if (!stall_s) begin
                data_r  <= nxt_data_s;
                carry_r <= nxt_carry_s;
                err_r   <= src_err_s;
            end else begin
                data_r  <= data_r;
                carry_r <= carry_r;
                err_r   <= err_r;
            end
        end

        // Amount and mode are only needed by the stages that follow.
        if (s < STAGES - 1) begin : g_fwd
            logic [AMT_W-1:0] amt_r;
            logic [2:0]       mode_r;

            // Forward the control fields that the later levels consume.
            always_ff @(posedge clk_i) begin
                if (!stall_s) begin
                    amt_r  <= src_amt_s;
                    mode_r <= src_mode_s;
                end else begin
                    amt_r  <= amt_r;
                    mode_r <= mode_r;
                end
            end
        end

        assign vld_vec_s[s] = vld_r;
    end

    assign last_vld_s   = g_stage[STAGES-1].vld_r;
    assign last_data_s  = g_stage[STAGES-1].data_r;
    assign last_carry_s = g_stage[STAGES-1].carry_r;
    assign last_err_s   = g_stage[STAGES-1].err_r;

    // Outputs are masked during reset so no stale operation is ever visible,
    // and payload outputs read as zero whenever no result is presented.
    assign out_valid_o = last_vld_s & ~rst_i;
    assign stall_s     = out_valid_o & ~out_ready_i;
    assign in_ready_o  = ~stall_s;
    assign out_data_o  = out_valid_o ? last_data_s : {WIDTH{1'b0}};
    assign out_carry_o = out_valid_o & last_carry_s;
    assign out_err_o   = out_valid_o & last_err_s;
    assign out_zero_o  = out_valid_o & (last_data_s == {WIDTH{1'b0}});
    assign busy_o      = (|vld_vec_s) & ~rst_i;
    assign op_count_o  = rst_i ? 16'd0 : cnt_r;

    // Completed-handshake counter; clear takes priority over a handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= 16'd0;
        end else if (cnt_clr_i) begin
            cnt_r <= 16'd0;
        end else if (out_valid_o && out_ready_i) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_rvlab_shift_unit.sv
// Scoreboard testbench for rvlab_shift_unit (WIDTH=32, STAGES=2).
// The driver pushes the hand-computed expected result when a request is
// accepted. A monitor pops and compares whenever a result is handed over.
module tb_rvlab_shift_unit;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    localparam logic [2:0] LSL = 3'd0;
    localparam logic [2:0] LSR = 3'd1;
    localparam logic [2:0] ASR = 3'd2;
    localparam logic [2:0] ROL = 3'd3;
    localparam logic [2:0] ROR = 3'd4;

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic        e;
        int          acc;
        bit          lat;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic [4:0]  in_amt_i;
    logic [2:0]  in_mode_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic        out_carry_o;
    logic        out_zero_o;
    logic        out_err_o;
    logic        cnt_clr_i;
    logic [15:0] op_count_o;
    logic        busy_o;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   w;
    bit   saw_not_ready;
    bit   saw_valid;

    rvlab_shift_unit #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_amt_i    (in_amt_i),
        .in_mode_i   (in_mode_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_carry_o (out_carry_o),
        .out_zero_o  (out_zero_o),
        .out_err_o   (out_err_o),
        .cnt_clr_i   (cnt_clr_i),
        .op_count_o  (op_count_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every handed-over result against the scoreboard head.
    always @(negedge clk_i) begin
        if (!in_ready_o) saw_not_ready = 1'b1;
        if (out_valid_o) begin
            if (out_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: actual data %h required no result", out_data_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data", out_data_o, mon_e.d);
                    check("carry", 32'(out_carry_o), 32'(mon_e.c));
                    check("zero", 32'(out_zero_o), 32'(mon_e.d == 32'd0));
                    check("err", 32'(out_err_o), 32'(mon_e.e));
                    if (mon_e.lat) check("latency", 32'(cyc - mon_e.acc), 32'd2);
                end
            end
        end else begin
            check("idle_data", out_data_o, 32'd0);
            check("idle_flags", 32'({out_carry_o, out_zero_o, out_err_o}), 32'd0);
        end
    end

    // Drive one request; push its expectation at the cycle it is accepted.
    task automatic issue(input logic [2:0] m, input logic [31:0] d, input logic [4:0] a,
                         input logic [31:0] ed, input logic ec, input logic ee,
                         input bit lat, output int waited);
        exp_t e;
        int   n;
        in_valid_i = 1'b1;
        in_mode_i  = m;
        in_data_i  = d;
        in_amt_i   = a;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (in_ready_o) begin
                e.d = ed; e.c = ec; e.e = ee; e.acc = cyc; e.lat = lat;
                exp_q.push_back(e);
                break;
            end
            n++;
            if (n > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL issue_timeout: actual in_ready 0 for %0d cycles required 1", n);
                break;
            end
        end
        waited = n;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = 32'd0; in_amt_i = 5'd0;
        in_mode_i = 3'd0; out_ready_i = 1'b1; cnt_clr_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_out_valid", 32'(out_valid_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_count", 32'(op_count_o), 32'd0);
        check("reset_in_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Directed vectors, back to back, no stall.
        issue(ASR,   32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0, 1'b1, w);
        check("first_accept_wait", 32'(w), 32'd0);
        issue(LSR,   32'h000000F0, 5'd5,  32'h00000007, 1'b1, 1'b0, 1'b1, w);
        issue(LSL,   32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0, 1'b1, w);
        issue(LSL,   32'h80000000, 5'd1,  32'h00000000, 1'b1, 1'b0, 1'b1, w);
        issue(ROL,   32'h80000001, 5'd1,  32'h00000003, 1'b1, 1'b0, 1'b1, w);
        issue(ROR,   32'h00000001, 5'd1,  32'h80000000, 1'b1, 1'b0, 1'b1, w);
        issue(3'd6,  32'h00001234, 5'd3,  32'h00001234, 1'b0, 1'b1, 1'b1, w);
        issue(LSR,   32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0, 1'b0, 1'b1, w);
        issue(ROR,   32'h12345678, 5'd8,  32'h78123456, 1'b0, 1'b0, 1'b1, w);
        issue(ASR,   32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b1, 1'b0, 1'b1, w);
        issue(ASR,   32'hF0000000, 5'd28, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, w);
        issue(LSR,   32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0, 1'b1, w);
        issue(ROL,   32'h12345678, 5'd4,  32'h23456781, 1'b1, 1'b0, 1'b1, w);
        issue(3'd5,  32'hABCD0000, 5'd7,  32'hABCD0000, 1'b0, 1'b1, 1'b1, w);
        issue(3'd7,  32'hFFFFFFFF, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, w);
        issue(LSL,   32'hFFFFFFFF, 5'd16, 32'hFFFF0000, 1'b1, 1'b0, 1'b1, w);
        issue(ASR,   32'h80000000, 5'd0,  32'h80000000, 1'b0, 1'b0, 1'b1, w);
        issue(ROL,   32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, w);
        issue(LSL,   32'h00000000, 5'd5,  32'h00000000, 1'b0, 1'b0, 1'b1, w);
        drain("drain_directed");
        check("count_directed", 32'(op_count_o), 32'd19);

        // Back-to-back issue with the consumer stalled for 5 cycles.
        cnt_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        cnt_clr_i = 1'b0;
        check("count_cleared", 32'(op_count_o), 32'd0);
        saw_not_ready = 1'b0;
        fork
            begin
                out_ready_i = 1'b0;
                repeat (5) @(posedge clk_i);
                #1;
                out_ready_i = 1'b1;
            end
            begin
                issue(LSL, 32'h00000003, 5'd2,  32'h0000000C, 1'b0, 1'b0, 1'b0, w);
                issue(LSR, 32'h00000100, 5'd8,  32'h00000001, 1'b0, 1'b0, 1'b0, w);
                issue(ROR, 32'h0000000F, 5'd4,  32'hF0000000, 1'b1, 1'b0, 1'b0, w);
                issue(ASR, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, w);
            end
        join
        drain("drain_stall");
        check("stall_in_ready_dropped", 32'(saw_not_ready), 32'd1);
        check("stall_count", 32'(op_count_o), 32'd4);

        // Reset with two operations in flight.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_mode_i   = LSL;
        in_data_i   = 32'h00000001;
        in_amt_i    = 5'd1;
        @(posedge clk_i);
        #1;
        in_data_i = 32'h00000002;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        check("inflight_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("inflight_reset_busy", 32'(busy_o), 32'd0);
        check("inflight_reset_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        saw_valid = 1'b0;
        repeat (10) begin
            @(negedge clk_i);
            if (out_valid_o) saw_valid = 1'b1;
        end
        check("no_result_after_reset", 32'(saw_valid), 32'd0);
        check("count_after_reset", 32'(op_count_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Counter clear coincident with a handshake.
        issue(LSR, 32'h0000FF00, 5'd8, 32'h000000FF, 1'b0, 1'b0, 1'b1, w);
        drain("drain_one");
        check("count_one", 32'(op_count_o), 32'd1);
        issue(ROL, 32'h00000001, 5'd3, 32'h00000008, 1'b0, 1'b0, 1'b1, w);
        @(posedge clk_i);
        #1;
        cnt_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        cnt_clr_i = 1'b0;
        check("clr_handshake_done", 32'(exp_q.size()), 32'd0);
        check("clr_wins_count", 32'(op_count_o), 32'd0);
        issue(LSL, 32'h00000001, 5'd4, 32'h00000010, 1'b0, 1'b0, 1'b1, w);
        drain("drain_final");
        check("count_after_clr", 32'(op_count_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
